// File: rtl/va_page_burst_splitter.sv
// va_page_burst_splitter
// Splits one (virtual address, line count) read command into Avalon-MM read
// bursts of at most MAX_BURST lines that never cross a PAGE_BYTES boundary,
// then counts returning beats and pulses cmd_done once all have arrived.
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   cmd_valid/ready/addr/lines/user   command handshake and payload
//   cmd_done, busy                    completion pulse, command in flight
//   avmm_read/address/burstcount/user read request (registered)
//   avmm_waitrequest                  request backpressure
//   avmm_readdatavalid                returned data beat
//   rsp_err                           sticky unexpected-beat flag
module va_page_burst_splitter #(
  parameter int unsigned ADDR_WIDTH      = 48,
  parameter int unsigned DATA_BYTES      = 64,
  parameter int unsigned BURST_CNT_WIDTH = 4,
  parameter int unsigned MAX_BURST       = 8,
  parameter int unsigned PAGE_BYTES      = 4096,
  parameter int unsigned LEN_WIDTH       = 20,
  parameter int unsigned USER_WIDTH      = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [LEN_WIDTH-1:0]       cmd_lines,
  input  logic [USER_WIDTH-1:0]      cmd_user,
  output logic                       cmd_done,
  output logic                       busy,
  output logic                       avmm_read,
  output logic [ADDR_WIDTH-1:0]      avmm_address,
  output logic [BURST_CNT_WIDTH-1:0] avmm_burstcount,
  output logic [USER_WIDTH-1:0]      avmm_user,
  input  logic                       avmm_waitrequest,
  input  logic                       avmm_readdatavalid,
  output logic                       rsp_err
);

  localparam int unsigned DB_LSB = $clog2(DATA_BYTES);
  localparam int unsigned PG_W   = $clog2(PAGE_BYTES);
  localparam int unsigned LPP    = PAGE_BYTES / DATA_BYTES;
  localparam int unsigned PL_W   = $clog2(LPP) + 1;
  localparam int unsigned CMP_W  = (LEN_WIDTH > PL_W) ? LEN_WIDTH : PL_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        addr_q, addr_d, addr_nx, cmd_addr_al;
  logic [LEN_WIDTH-1:0]         rem_q, rem_d, rem_nx;
  logic [LEN_WIDTH-1:0]         exp_q, exp_d;
  logic [LEN_WIDTH-1:0]         rcv_q, rcv_d;
  logic [USER_WIDTH-1:0]        user_q, user_d;
  logic [BURST_CNT_WIDTH-1:0]   burst_q, burst_d;
  logic                         err_d;

  // Burst size: min(remaining, MAX_BURST, lines left in the current page).
  function automatic logic [BURST_CNT_WIDTH-1:0] calc_burst(
    input logic [PG_W-DB_LSB-1:0] page_line,
    input logic [LEN_WIDTH-1:0]   rem
  );
    logic [CMP_W-1:0] to_end;
    logic [CMP_W-1:0] b;
    to_end = CMP_W'(LPP) - CMP_W'(page_line);
    b      = CMP_W'(MAX_BURST);
    if (to_end < b) b = to_end;
    if (CMP_W'(rem) < b) b = CMP_W'(rem);
    return BURST_CNT_WIDTH'(b);
  endfunction

  assign avmm_address    = addr_q;
  assign avmm_burstcount = burst_q;
  assign avmm_user       = user_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    exp_d       = exp_q;
    rcv_d       = rcv_q;
    user_d      = user_q;
    burst_d     = burst_q;
    err_d       = rsp_err;
    cmd_addr_al = cmd_addr & ~ADDR_WIDTH'(DATA_BYTES - 1);
    addr_nx     = addr_q + (ADDR_WIDTH'(burst_q) << DB_LSB);
    rem_nx      = rem_q - LEN_WIDTH'(burst_q);

    unique case (state_q)
      S_IDLE: begin
        if (avmm_readdatavalid) err_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr_al;
          rem_d  = cmd_lines;
          exp_d  = cmd_lines;
          rcv_d  = '0;
          user_d = cmd_user;
          if (cmd_lines == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            burst_d = calc_burst(cmd_addr_al[PG_W-1:DB_LSB], cmd_lines);
          end
        end
      end
      S_ISSUE: begin
        if (avmm_readdatavalid) rcv_d = rcv_q + LEN_WIDTH'(1);
        // avmm_read is always high in ISSUE, so acceptance is just !waitrequest.
        if (!avmm_waitrequest) begin
          addr_d = addr_nx;
          rem_d  = rem_nx;
          if (rem_nx == '0) state_d = S_DRAIN;
          else burst_d = calc_burst(addr_nx[PG_W-1:DB_LSB], rem_nx);
        end
      end
      S_DRAIN: begin
        if (avmm_readdatavalid) rcv_d = rcv_q + LEN_WIDTH'(1);
        if (rcv_d == exp_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (avmm_readdatavalid) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      exp_q     <= '0;
      rcv_q     <= '0;
      user_q    <= '0;
      burst_q   <= '0;
      cmd_ready <= 1'b0;
      avmm_read <= 1'b0;
      cmd_done  <= 1'b0;
      busy      <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      exp_q     <= exp_d;
      rcv_q     <= rcv_d;
      user_q    <= user_d;
      burst_q   <= burst_d;
      cmd_ready <= (state_d == S_IDLE);
      avmm_read <= (state_d == S_ISSUE);
      cmd_done  <= (state_d == S_DONE);
      busy      <= (state_d == S_ISSUE) || (state_d == S_DRAIN);
      rsp_err   <= err_d;
    end
  end

endmodule

// File: tb/tb_va_page_burst_splitter.sv
// Directed bench for va_page_burst_splitter with a burst scoreboard queue.
module tb_va_page_burst_splitter;

  typedef struct packed {
    logic [47:0] addr;
    logic [3:0]  cnt;
    logic [0:0]  user;
  } burst_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [47:0] cmd_addr;
  logic [19:0] cmd_lines;
  logic [0:0]  cmd_user;
  logic        cmd_done;
  logic        busy;
  logic        avmm_read;
  logic [47:0] avmm_address;
  logic [3:0]  avmm_burstcount;
  logic [0:0]  avmm_user;
  logic        avmm_waitrequest;
  logic        avmm_readdatavalid;
  logic        rsp_err;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     done_cnt = 0;
  int     exp_dones = 0;
  burst_t exp_q[$];

  va_page_burst_splitter dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_addr           (cmd_addr),
    .cmd_lines          (cmd_lines),
    .cmd_user           (cmd_user),
    .cmd_done           (cmd_done),
    .busy               (busy),
    .avmm_read          (avmm_read),
    .avmm_address       (avmm_address),
    .avmm_burstcount    (avmm_burstcount),
    .avmm_user          (avmm_user),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdatavalid (avmm_readdatavalid),
    .rsp_err            (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Mid-cycle sampling: check presented bursts against the scoreboard.
  task automatic sample();
    burst_t obs;
    if (reset_n === 1'b1 && avmm_read === 1'b1) begin
      chk("burst_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        obs = '{addr: avmm_address, cnt: avmm_burstcount, user: avmm_user};
        chk("burst", 64'(obs), 64'(exp_q[0]));
        if (avmm_waitrequest === 1'b0) void'(exp_q.pop_front());
      end
    end
    if (cmd_done === 1'b1) done_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [47:0] a, input logic [3:0] c, input logic [0:0] u);
    exp_q.push_back('{addr: a, cnt: c, user: u});
  endtask

  task automatic issue_cmd(input logic [47:0] a, input logic [19:0] n, input logic [0:0] u);
    chk("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_lines = n;
    cmd_user  = u;
    tick();
    cmd_valid = 1'b0;
    exp_dones++;
  endtask

  task automatic beats(input int n);
    avmm_readdatavalid = 1'b1;
    repeat (n) tick();
    avmm_readdatavalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (cmd_done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk("done_seen", 64'(cmd_done), 64'd1);
    chk("busy_at_done", 64'(busy), 64'd0);
    tick();
    chk("done_pulse", 64'(cmd_done), 64'd0);
    chk("ready_after_done", 64'(cmd_ready), 64'd1);
    chk("done_count", 64'(done_cnt), 64'(exp_dones));
  endtask

  initial begin
    reset_n            = 1'b0;
    cmd_valid          = 1'b0;
    cmd_addr           = '0;
    cmd_lines          = '0;
    cmd_user           = '0;
    avmm_waitrequest   = 1'b0;
    avmm_readdatavalid = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_read", 64'(avmm_read), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(cmd_done), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_addr", 64'(avmm_address), 64'd0);
    chk("rst_cnt", 64'(avmm_burstcount), 64'd0);
    chk("rst_user", 64'(avmm_user), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(cmd_ready), 64'd1);

    // Aligned multi-burst
    push(48'h1000, 4'd8, 1'b1);
    push(48'h1200, 4'd8, 1'b1);
    push(48'h1400, 4'd4, 1'b1);
    issue_cmd(48'h1000, 20'd20, 1'b1);
    chk("s1_latency", 64'(avmm_read), 64'd1);
    chk("s1_busy", 64'(busy), 64'd1);
    chk("s1_ready_low", 64'(cmd_ready), 64'd0);
    repeat (3) tick();
    chk("s1_read_drop", 64'(avmm_read), 64'd0);
    chk("s1_all_issued", 64'(exp_q.size()), 64'd0);
    beats(20);
    wait_done(5);

    // Page crossing, aligned then misaligned start
    push(48'h1FC0, 4'd1, 1'b0);
    push(48'h2000, 4'd2, 1'b0);
    issue_cmd(48'h1FC0, 20'd3, 1'b0);
    repeat (2) tick();
    chk("s2_read_drop", 64'(avmm_read), 64'd0);
    chk("s2_all_issued", 64'(exp_q.size()), 64'd0);
    beats(3);
    wait_done(5);

    push(48'h1FC0, 4'd1, 1'b1);
    push(48'h2000, 4'd2, 1'b1);
    issue_cmd(48'h1FC5, 20'd3, 1'b1);
    repeat (2) tick();
    chk("s2b_read_drop", 64'(avmm_read), 64'd0);
    chk("s2b_all_issued", 64'(exp_q.size()), 64'd0);
    beats(3);
    wait_done(5);

    // Backpressure on the second burst
    push(48'h1000, 4'd8, 1'b0);
    push(48'h1200, 4'd8, 1'b0);
    push(48'h1400, 4'd4, 1'b0);
    issue_cmd(48'h1000, 20'd20, 1'b0);
    tick();
    avmm_waitrequest = 1'b1;
    repeat (5) tick();
    chk("s3_held_remaining", 64'(exp_q.size()), 64'd2);
    avmm_waitrequest = 1'b0;
    repeat (2) tick();
    chk("s3_read_drop", 64'(avmm_read), 64'd0);
    chk("s3_all_issued", 64'(exp_q.size()), 64'd0);
    beats(20);
    wait_done(5);

    // Zero length
    issue_cmd(48'h3000, 20'd0, 1'b0);
    chk("s4_no_read", 64'(avmm_read), 64'd0);
    chk("s4_done", 64'(cmd_done), 64'd1);
    chk("s4_ready_low", 64'(cmd_ready), 64'd0);
    tick();
    chk("s4_ready", 64'(cmd_ready), 64'd1);
    chk("s4_done_pulse", 64'(cmd_done), 64'd0);
    chk("s4_done_count", 64'(done_cnt), 64'(exp_dones));

    // Early data during issue, late final beat
    push(48'h1000, 4'd8, 1'b1);
    push(48'h1200, 4'd8, 1'b1);
    push(48'h1400, 4'd4, 1'b1);
    issue_cmd(48'h1000, 20'd20, 1'b1);
    tick();
    avmm_waitrequest   = 1'b1;
    avmm_readdatavalid = 1'b1;
    repeat (8) tick();
    avmm_waitrequest = 1'b0;
    repeat (11) tick();
    avmm_readdatavalid = 1'b0;
    chk("s5_all_issued", 64'(exp_q.size()), 64'd0);
    repeat (10) tick();
    chk("s5_no_early_done", 64'(cmd_done), 64'd0);
    chk("s5_still_busy", 64'(busy), 64'd1);
    chk("s5_done_count_pre", 64'(done_cnt), 64'(exp_dones - 1));
    beats(1);
    wait_done(5);

    // Stray beat in IDLE
    chk("err_clear", 64'(rsp_err), 64'd0);
    beats(1);
    tick();
    chk("err_set", 64'(rsp_err), 64'd1);
    tick();
    chk("err_sticky", 64'(rsp_err), 64'd1);

    // Reset during the second burst
    push(48'h5000, 4'd8, 1'b1);
    push(48'h5200, 4'd8, 1'b1);
    push(48'h5400, 4'd4, 1'b1);
    issue_cmd(48'h5000, 20'd20, 1'b1);
    exp_dones--;
    tick();
    chk("s6_second_burst", 64'(avmm_read), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_async_read", 64'(avmm_read), 64'd0);
    chk("s6_async_busy", 64'(busy), 64'd0);
    chk("s6_async_ready", 64'(cmd_ready), 64'd0);
    chk("s6_async_err", 64'(rsp_err), 64'd0);
    chk("s6_async_addr", 64'(avmm_address), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("s6_ready", 64'(cmd_ready), 64'd1);
    repeat (10) tick();
    chk("s6_no_done", 64'(done_cnt), 64'(exp_dones));
    chk("s6_idle_read", 64'(avmm_read), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
